// File: rtl/temp_scratchpad_check_if.sv
// Byte-stream handshake between the 1-wire temperature reader (master)
// and the scratchpad checker (slave).
//   frame_start : one-cycle pulse, begins a new 9-byte scratchpad frame
//   byte_valid  : byte_data is valid, held by the master until accepted
//   byte_data   : scratchpad byte, byte0..byte8 in order
//   in_ready    : slave can accept a byte this cycle
interface temp_scratchpad_check_if;
    logic       frame_start;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic       in_ready;

    modport master (output frame_start, output byte_valid, output byte_data, input in_ready);
    modport slave  (input frame_start, input byte_valid, input byte_data, output in_ready);
endinterface

// File: rtl/temp_scratchpad_check.sv
// DS18B20 scratchpad checker: receives the 9-byte scratchpad, runs the
// Dallas/Maxim CRC-8 one bit per cycle, and on a good frame publishes the
// temperature and updates the hysteretic over/under-temperature alarms.
// Corrupt frames pulse crc_err and bump a saturating error counter.
//   clk, rst   : system clock, asynchronous active-low reset
//   up         : byte-stream handshake (slave side)
//   done       : one-cycle pulse, good frame published
//   crc_err    : one-cycle pulse, frame rejected
//   temp_raw   : signed 1/16 degC, {byte1, byte0}
//   temp_deg   : signed integer degC (floor, saturated)
//   temp_valid : sticky, a good frame has been seen
//   alarm_hi/lo: temperature alarms with hysteresis
//   err_cnt    : rejected-frame count, saturates at 255
//
// state | meaning
// IDLE  | waiting for frame_start, no bytes accepted
// RECV  | in_ready high, waiting for the next byte
// SHIFT | clocking the held byte through the CRC, LSB first, 8 cycles
// CHECK | all 9 bytes consumed, publish or reject
module temp_scratchpad_check #(
    parameter int T_HI = 85,
    parameter int T_LO = -10,
    parameter int HYST = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    temp_scratchpad_check_if.slave up,
    output logic                   done,
    output logic                   crc_err,
    output logic [15:0]            temp_raw,
    output logic [7:0]             temp_deg,
    output logic                   temp_valid,
    output logic                   alarm_hi,
    output logic                   alarm_lo,
    output logic [7:0]             err_cnt
);

    typedef enum logic [1:0] {IDLE, RECV, SHIFT, CHECK} state_t;

    state_t             state, state_next;
    logic [7:0]         crc, crc_next, sreg;
    logic [2:0]         bit_cnt;
    logic [3:0]         byte_cnt;
    logic [7:0]         byte0, byte1;
    logic               any_nz;
    logic               accept, fb, frame_good;
    logic signed [15:0] raw_s, shifted;
    logic signed [7:0]  deg_new;
    logic               hi_next, lo_next;

    assign up.in_ready = (state == RECV);

    always_comb begin
        accept     = (state == RECV) && up.byte_valid && !up.frame_start;
        fb         = crc[0] ^ sreg[0];
        crc_next   = {1'b0, crc[7:1]} ^ (fb ? 8'h8C : 8'h00);
        // An all-zero frame has a zero CRC too; it is the stuck-low bus.
        frame_good = (crc == 8'h00) && any_nz;
    end

    always_comb begin
        raw_s   = {byte1, byte0};
        shifted = raw_s >>> 4;
        if (shifted > 16'sd127)
            deg_new = 8'sh7F;
        else if (shifted < -16'sd128)
            deg_new = -8'sd128;
        else
            deg_new = shifted[7:0];

        hi_next = alarm_hi;
        if (int'(deg_new) >= T_HI)
            hi_next = 1'b1;
        else if (int'(deg_new) <= T_HI - HYST)
            hi_next = 1'b0;

        lo_next = alarm_lo;
        if (int'(deg_new) <= T_LO)
            lo_next = 1'b1;
        else if (int'(deg_new) >= T_LO + HYST)
            lo_next = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (up.frame_start) begin
            state_next = RECV;
        end else begin
            case (state)
                IDLE:  state_next = IDLE;
                RECV:  if (accept) state_next = SHIFT;
                SHIFT: if (bit_cnt == 3'd7) state_next = (byte_cnt == 4'd8) ? CHECK : RECV;
                CHECK: state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc        <= 8'h00;
            sreg       <= 8'h00;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 4'd0;
            byte0      <= 8'h00;
            byte1      <= 8'h00;
            any_nz     <= 1'b0;
            done       <= 1'b0;
            crc_err    <= 1'b0;
            temp_raw   <= 16'h0000;
            temp_deg   <= 8'h00;
            temp_valid <= 1'b0;
            alarm_hi   <= 1'b0;
            alarm_lo   <= 1'b0;
            err_cnt    <= 8'h00;
        end else begin
            done    <= 1'b0;
            crc_err <= 1'b0;
            if (up.frame_start) begin
                // Also covers a restart from CHECK: the old frame gets no verdict.
                crc      <= 8'h00;
                bit_cnt  <= 3'd0;
                byte_cnt <= 4'd0;
                byte0    <= 8'h00;
                byte1    <= 8'h00;
                any_nz   <= 1'b0;
            end else begin
                case (state)
                    RECV: begin
                        if (accept) begin
                            sreg    <= up.byte_data;
                            bit_cnt <= 3'd0;
                            if (up.byte_data != 8'h00) any_nz <= 1'b1;
                            if (byte_cnt == 4'd0) byte0 <= up.byte_data;
                            if (byte_cnt == 4'd1) byte1 <= up.byte_data;
                        end
                    end
                    SHIFT: begin
                        crc     <= crc_next;
                        sreg    <= {1'b0, sreg[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7 && byte_cnt != 4'd8)
                            byte_cnt <= byte_cnt + 4'd1;
                    end
                    CHECK: begin
                        if (frame_good) begin
                            temp_raw   <= raw_s;
                            temp_deg   <= deg_new;
                            temp_valid <= 1'b1;
                            alarm_hi   <= hi_next;
                            alarm_lo   <= lo_next;
                            done       <= 1'b1;
                        end else begin
                            crc_err <= 1'b1;
                            if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
